pll_lock_supervisor: RTL

PLL_LOCK_SUPERVISOR -- requirements
Module: pll_lock_supervisor

---
 rtl/pll_lock_supervisor.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/pll_lock_supervisor.sv
// -----------------------------------------------------------------------------
// pll_lock_supervisor
//
// Sequences PLL bring-up and supervises PLL lock. It pulses the PLL reset,
// waits for a lock indication that stays high for a set number of cycles, and
// then releases the downstream system reset. A lock that never settles times
// out and restarts the sequence. A lock that drops while running immediately
// restarts the sequence. Two saturating 8-bit event counters record these
// timeouts and lock losses.
//
// Parameters
//   PLL_RST_CYCLES      PLL reset pulse width in refclk cycles (2..65535)
//   LOCK_STABLE_CYCLES  consecutive lock cycles before release (1..2^20-1)
//   LOCK_TIMEOUT_CYCLES cycles allowed to reach stable lock (1..2^24-1),
//                       must exceed LOCK_STABLE_CYCLES
//
// Ports
//   refclk        in   single clock, all logic on rising edge
//   rst           in   asynchronous active-high reset
//   locked_in     in   PLL lock flag, asynchronous to refclk
//   clear_counts  in   synchronous clear of both event counters
//   pll_rst       out  reset request to the PLL (active-high)
//   sys_rst       out  downstream system reset (active-high)
//   ready         out  high only in RUN
//   state         out  0=PLL_RST 1=WAIT_LOCK 2=STABLE 3=RUN
//   lock_loss_cnt out  RUN-to-PLL_RST transitions caused by lock loss
//   timeout_cnt   out  lock timeouts
// -----------------------------------------------------------------------------
module pll_lock_supervisor #(
    parameter int PLL_RST_CYCLES      = 16,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 100000
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       locked_in,
    input  logic       clear_counts,
    output logic       pll_rst,
    output logic       sys_rst,
    output logic       ready,
    output logic [1:0] state,
    output logic [7:0] lock_loss_cnt,
    output logic [7:0] timeout_cnt
);

    typedef enum logic [1:0] {
        ST_PLL_RST   = 2'd0,
        ST_WAIT_LOCK = 2'd1,
        ST_STABLE    = 2'd2,
        ST_RUN       = 2'd3
    } state_t;

    // Terminal counts: a phase ends on the edge where its counter holds N-1,
    // so that the phase lasts exactly N cycles.
    localparam logic [15:0] RST_LAST     = 16'(PLL_RST_CYCLES - 1);
    localparam logic [19:0] STABLE_LAST  = 20'(LOCK_STABLE_CYCLES - 1);
    localparam logic [23:0] TIMEOUT_LAST = 24'(LOCK_TIMEOUT_CYCLES - 1);

    logic        r_lk_meta;
    logic        r_lk;
    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_rst_cnt;
    logic [19:0] r_stable_cnt;
    logic [23:0] r_to_cnt;
    logic [7:0]  r_lock_loss_cnt;
    logic [7:0]  r_timeout_cnt;
    logic        r_pll_rst;
    logic        r_sys_rst;
    logic        r_ready;
    logic        w_timeout;
    logic        w_lock_loss;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // locked_in is asynchronous; only r_lk is used by the rest of the logic.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            r_lk_meta <= 1'b0;
            r_lk      <= 1'b0;
        end else begin
            r_lk_meta <= locked_in;
            r_lk      <= r_lk_meta;
        end
    end

    // Timeout takes priority over the lock flag in the same cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_lock_loss = 1'b0;
        w_timeout   = ((r_state == ST_WAIT_LOCK) || (r_state == ST_STABLE)) &&
                      (r_to_cnt == TIMEOUT_LAST);
        case (r_state)
            ST_PLL_RST: begin
                if (r_rst_cnt == RST_LAST) w_state_nxt = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
                if (w_timeout)  w_state_nxt = ST_PLL_RST;
                else if (r_lk)  w_state_nxt = ST_STABLE;
            end
            ST_STABLE: begin
                if (w_timeout)                       w_state_nxt = ST_PLL_RST;
                else if (!r_lk)                      w_state_nxt = ST_WAIT_LOCK;
                else if (r_stable_cnt == STABLE_LAST) w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (!r_lk) begin
                    w_state_nxt = ST_PLL_RST;
                    w_lock_loss = 1'b1;
                end
            end
            default: w_state_nxt = ST_PLL_RST;
        endcase
    end

    // Outputs are decoded from the next state so they move on the same edge
    // as the state register.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            r_state         <= ST_PLL_RST;
            r_pll_rst       <= 1'b1;
            r_sys_rst       <= 1'b1;
            r_ready         <= 1'b0;
            r_rst_cnt       <= '0;
            r_stable_cnt    <= '0;
            r_to_cnt        <= '0;
            r_lock_loss_cnt <= '0;
            r_timeout_cnt   <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_pll_rst <= (w_state_nxt == ST_PLL_RST);
            r_sys_rst <= (w_state_nxt != ST_RUN);
            r_ready   <= (w_state_nxt == ST_RUN);

            // Counts only while in PLL_RST; every entry starts from zero.
            if (r_state == ST_PLL_RST) r_rst_cnt <= r_rst_cnt + 16'd1;
            else                       r_rst_cnt <= '0;

            // Any lk=0 cycle in STABLE restarts the run of lock cycles.
            if ((r_state == ST_STABLE) && r_lk) r_stable_cnt <= r_stable_cnt + 20'd1;
            else                                r_stable_cnt <= '0;

            // Spans WAIT_LOCK and STABLE together, so lock glitches do not
            // extend the allowed window.
            if ((r_state == ST_WAIT_LOCK) || (r_state == ST_STABLE))
                r_to_cnt <= w_timeout ? '0 : r_to_cnt + 24'd1;
            else
                r_to_cnt <= '0;

            if (clear_counts) begin
                r_lock_loss_cnt <= '0;
                r_timeout_cnt   <= '0;
            end else begin
                if (w_lock_loss) r_lock_loss_cnt <= sat_inc(r_lock_loss_cnt);
                if (w_timeout)   r_timeout_cnt   <= sat_inc(r_timeout_cnt);
            end
        end
    end

    assign state         = r_state;
    assign pll_rst       = r_pll_rst;
    assign sys_rst       = r_sys_rst;
    assign ready         = r_ready;
    assign lock_loss_cnt = r_lock_loss_cnt;
    assign timeout_cnt   = r_timeout_cnt;

endmodule
